shift_exec_stage: RTL
=====================

# shift_exec_stage

Registered execute-stage shift unit that feeds the writeback path from the shift datapath. Decodes R-type shift functs (SLL, SRL, SRA, SLLV, SRLV, SRAV), selects the shift amount from the instruction field or rs, and computes the result. The result is captured in a single output register behind a valid/ready handshake, with flush support for pipeline redirects. Sits between instruction decode/register read and the writeback register.

## Interface
Parameters:
- none; datapath fixed at 32 bits, shift amount 5 bits.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge
- rst_i  input  1  reset; synchronous, active-high
- in_valid_i  input  1  upstream presents an operation
- in_ready_o  output  1  stage can accept; equals !out_valid_o || out_ready_i
- funct_i  input  6  instruction funct field
- shamt_i  input  5  instruction shamt field
- rot_i  input  1  rotate select (instr bit 21 for SRL, bit 6 for SRLV)
- rs_data_i  input  32  rs operand; bits [4:0] are the variable shift amount
- rt_data_i  input  32  rt operand; the value shifted
- rd_addr_i  input  5  destination register
- flush_i  input  1  discard held result and same-cycle input
- out_valid_o  output  1  result register holds a valid operation
- out_ready_i  input  1  downstream consumes result
- result_o  output  32  shift result
- rd_addr_o  output  5  destination register of result
- illegal_o  output  1  held operation had an unsupported funct

## Operation
- Funct decode: 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV; any other value is illegal.
- Amount: immediate forms use shamt_i; variable forms use rs_data_i[4:0]; rs_data_i[31:5] ignored.
- SLL: rt << amt, zero fill. SRL: rt >> amt, zero fill. SRA: signed rt >>> amt, sign fill.
- amt = 0: result = rt_data_i unchanged for all forms.
- Illegal funct: operation still accepted; result_o = 0, illegal_o = 1, rd_addr_o passes through.
- rd_addr_i = 0 is not special; passed through unchanged.
- Accept = in_valid_i && in_ready_o && !flush_i. On accept, result, rd_addr, and illegal register; out_valid_o = 1.
- Hold: while out_valid_o && !out_ready_i, all outputs stable and in_ready_o = 0.
- Drain without refill: out_valid_o && out_ready_i && no accept -> out_valid_o = 0 next cycle. result_o, rd_addr_o, and illegal_o keep their last values.
- Back-to-back: out_ready_i = 1 allows an accept every cycle, giving full throughput.

## Timing
- Latency: 1 cycle, from accept edge to out_valid_o.
- in_ready_o is combinational from out_valid_o and out_ready_i; no combinational path from in_valid_i to in_ready_o.
- Reset (rst_i high at edge): out_valid_o = 0, result_o = 0, rd_addr_o = 0, illegal_o = 0. Inputs are ignored that cycle. Reset wins over flush and accept. Reset mid-hold drops the held result.
- Flush (flush_i high at edge): out_valid_o = 0 next cycle. Any same-cycle input is dropped even if in_valid_i and in_ready_o are high. Data registers are unchanged. Flush beats accept.
- Simultaneous drain and accept: the new result replaces the old in the same edge, and out_valid_o stays 1.

## Configuration
- SHIFT_ROTATE_EN defined: SRL with rot_i = 1 is ROTR by shamt_i, and SRLV with rot_i = 1 is ROTRV by rs_data_i[4:0]. Rotate uses (rt >> amt) | (rt << (32 - amt)); amt = 0 gives rt unchanged. rot_i has no effect on other functs.
- SHIFT_ROTATE_EN undefined: rot_i is ignored. SRL and SRLV are always logical shifts, and no rotate logic is synthesized.

## Test plan
- Reset, then SRA with rt = 0x80000000, shamt = 4, rd = 5, out_ready = 1 -> next cycle out_valid = 1, result = 0xF8000000, rd_addr = 5, illegal = 0.
- SRLV with rs = 0xFFFFFFE4 (amt 4), rt = 0xF0000000 -> result = 0x0F000000. SLLV with the same operands -> 0x00000000.
- Backpressure: accept SLL rt = 1, shamt = 31, then hold out_ready = 0 for 3 cycles while in_valid stays 1. Required: result = 0x80000000 stable, in_ready = 0 throughout. Raising out_ready accepts the next op in that same cycle, and out_valid stays 1.
- Flush: assert flush_i while holding a result and while in_valid = 1 -> out_valid = 0 next cycle, and the offered op never appears.
- Illegal funct 0x20 with rt = 0x12345678 -> out_valid = 1, illegal = 1, result = 0x00000000.
- SRL with rot = 1, rt = 0x0000000F, shamt = 4 -> result = 0xF0000000 with SHIFT_ROTATE_EN defined, 0x00000000 without it.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Registered execute-stage shift unit: decodes R-type shift functs and holds one result behind valid/ready.
// Optional rotate support (ROTR/ROTRV via rot_i) is enabled by defining SHIFT_ROTATE_EN.
module shift_exec_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic        rot_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        illegal_o
);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;

  logic [4:0]  amt;
  logic [31:0] shifted;
  logic        legal;
  logic        accept;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // Upstream: in_valid_i && in_ready_o (and no flush). Downstream: out_valid_o && out_ready_i.
  // in_ready_o depends only on the output register and out_ready_i, never on in_valid_i.
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // The variable forms all have funct bit 2 set.
  assign amt = funct_i[2] ? rs_data_i[4:0] : shamt_i;

`ifdef SHIFT_ROTATE_EN
  logic [63:0] rot_wide;
  assign rot_wide = {rt_data_i, rt_data_i} >> amt;
  logic unused_rs;
  assign unused_rs = ^rs_data_i[31:5];
`else
  logic unused_rs;
  assign unused_rs = ^{rs_data_i[31:5], rot_i};
`endif

  always_comb begin
    shifted = '0;
    legal   = 1'b1;
    case (funct_i)
      F_SLL, F_SLLV: shifted = rt_data_i << amt;
      F_SRL, F_SRLV: begin
        shifted = rt_data_i >> amt;
`ifdef SHIFT_ROTATE_EN
        if (rot_i) shifted = rot_wide[31:0];
`endif
      end
      F_SRA, F_SRAV: shifted = $signed(rt_data_i) >>> amt;
      default: begin
        shifted = '0;
        legal   = 1'b0;
      end
    endcase
  end

  // Flush clears only the valid bit; data registers keep their last contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      rd_addr_o   <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      result_o    <= shifted;
      rd_addr_o   <= rd_addr_i;
      illegal_o   <= !legal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
